demux_sched_ctrl: RTL and testbench

Scheduler and controller for the 1:2 eight-bit demultiplexer datapath. It accepts one upstream valid/data stream and decides, per word, which of two downstream lanes receives it. It either alternates round-robin, skipping a full lane, or routes by a destination bit in the word. It drives the demux selector, produces registered per-lane valid/data, applies backpressure upstream and optionally counts words per lane.

---
 rtl/demux_sched_ctrl_pkg.sv | 30 +++
 rtl/demux_sched_ctrl_if.sv | 33 +++
 rtl/demux_sched_cnt.sv | 18 +
 rtl/demux_sched_ctrl.sv | 98 +++++++++
 tb/tb_demux_sched_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/demux_sched_ctrl_pkg.sv
// Shared types and defaults for the demux scheduler/controller.
// Optional per-lane counters are enabled by DEMUX_SCHED_CNT_EN.
package demux_sched_ctrl_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int CNT_W_DEF  = 8;

   localparam logic [1:0] ESTADO_IDLE   = 2'd0;
   localparam logic [1:0] ESTADO_ACTIVE = 2'd1;
   localparam logic [1:0] ESTADO_STALL  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE   = ESTADO_IDLE,
      ST_ACTIVE = ESTADO_ACTIVE,
      ST_STALL  = ESTADO_STALL
   } state_t;

   function automatic state_t next_state(
      input logic valid,
      input logic acc
   );
      if (!valid)
         return ST_IDLE;
      else if (acc)
         return ST_ACTIVE;
      else
         return ST_STALL;
   endfunction

endpackage

// File: rtl/demux_sched_ctrl_if.sv
// Upstream, lane-status and output bundle of the demux scheduler.
// The slave side is the scheduler, the master side drives it.
interface demux_sched_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
);
   logic              valid_in;
   logic [DATA_W-1:0] data_in;
   logic              mode;
   logic              full0;
   logic              full1;
   logic              ready_out;
   logic              selector;
   logic              validout0;
   logic              validout1;
   logic [DATA_W-1:0] dataout0;
   logic [DATA_W-1:0] dataout1;
   logic [1:0]        estado;
   logic [CNT_W-1:0]  count0;
   logic [CNT_W-1:0]  count1;

   modport master (
      output valid_in, data_in, mode, full0, full1,
      input  ready_out, selector, validout0, validout1,
      input  dataout0, dataout1, estado, count0, count1
   );

   modport slave (
      input  valid_in, data_in, mode, full0, full1,
      output ready_out, selector, validout0, validout1,
      output dataout0, dataout1, estado, count0, count1
   );
endinterface

// File: rtl/demux_sched_cnt.sv
// Wrapping per-lane word counter with enable.
module demux_sched_cnt #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/demux_sched_ctrl.sv
// 1:2 demux scheduler: round-robin or routed lane choice, backpressure.
// Define DEMUX_SCHED_CNT_EN to build the per-lane word counters.
module demux_sched_ctrl
   import demux_sched_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input logic clk,
   input logic reset,
   demux_sched_ctrl_if.slave bus
);

   logic              ptr;
   logic              target;
   logic              ready;
   logic              accept;
   logic              sel_q;
   logic              v0_q;
   logic              v1_q;
   logic [DATA_W-1:0] d0_q;
   logic [DATA_W-1:0] d1_q;
   state_t            state;

   always_comb begin
      target = 1'b0;
      ready  = 1'b0;
      if (bus.mode) begin
         target = bus.data_in[DATA_W-1];
         ready  = target ? !bus.full1 : !bus.full0;
      end else begin
         // skip the pointed lane when it is full
         target = (ptr ? bus.full1 : bus.full0) ? ~ptr : ptr;
         ready  = !(bus.full0 & bus.full1);
      end
      if (reset)
         ready = 1'b0;
   end

   assign accept = bus.valid_in & ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr   <= 1'b0;
         sel_q <= 1'b0;
         v0_q  <= 1'b0;
         v1_q  <= 1'b0;
         d0_q  <= '0;
         d1_q  <= '0;
         state <= ST_IDLE;
      end else begin
         v0_q  <= accept & ~target;
         v1_q  <= accept & target;
         state <= next_state(bus.valid_in, accept);
         if (accept) begin
            sel_q <= target;
            if (target)
               d1_q <= bus.data_in;
            else
               d0_q <= bus.data_in;
            if (!bus.mode)
               ptr <= ~target;
         end
      end
   end

   assign bus.ready_out = ready;
   assign bus.selector  = sel_q;
   assign bus.validout0 = v0_q;
   assign bus.validout1 = v1_q;
   assign bus.dataout0  = d0_q;
   assign bus.dataout1  = d1_q;
   assign bus.estado    = state;

`ifdef DEMUX_SCHED_CNT_EN
   demux_sched_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt0 (
      .clk  (clk),
      .reset(reset),
      .en   (accept & ~target),
      .count(bus.count0)
   );

   demux_sched_cnt #(
      .CNT_W(CNT_W)
   ) u_cnt1 (
      .clk  (clk),
      .reset(reset),
      .en   (accept & target),
      .count(bus.count1)
   );
`else
   assign bus.count0 = '0;
   assign bus.count1 = '0;
`endif

endmodule

// File: tb/tb_demux_sched_ctrl.sv
// Scoreboard bench for demux_sched_ctrl.
module tb_demux_sched_ctrl;

   typedef struct packed {
      logic       lane;
      logic [7:0] data;
   } exp_t;

   logic clk;
   logic reset;
   int   nvec;
   int   nmis;

   exp_t       sb[$];
   logic       m_ptr;
   logic       m_sel;
   logic [7:0] m_d0;
   logic [7:0] m_d1;
   logic [7:0] m_c0;
   logic [7:0] m_c1;

   demux_sched_ctrl_if #(.DATA_W(8), .CNT_W(8)) bus ();

   demux_sched_ctrl #(
      .DATA_W(8),
      .CNT_W (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] cexp(input logic [7:0] c);
`ifdef DEMUX_SCHED_CNT_EN
      return c;
`else
      return 8'd0 & c;
`endif
   endfunction

   task automatic model_reset();
      m_ptr = 1'b0;
      m_sel = 1'b0;
      m_d0  = '0;
      m_d1  = '0;
      m_c0  = '0;
      m_c1  = '0;
      sb.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rdy"}, {31'd0, bus.ready_out}, 0);
      chk({tag, "_v0"}, {31'd0, bus.validout0}, 0);
      chk({tag, "_v1"}, {31'd0, bus.validout1}, 0);
      chk({tag, "_d0"}, {24'd0, bus.dataout0}, 0);
      chk({tag, "_d1"}, {24'd0, bus.dataout1}, 0);
      chk({tag, "_sel"}, {31'd0, bus.selector}, 0);
      chk({tag, "_st"}, {30'd0, bus.estado}, 0);
      chk({tag, "_c0"}, {24'd0, bus.count0}, 0);
      chk({tag, "_c1"}, {24'd0, bus.count1}, 0);
   endtask

   // called at a negedge; reset rises between edges with a word offered
   task automatic do_reset(input logic [7:0] d);
      bus.valid_in = 1'b1;
      bus.data_in  = d;
      reset = 1'b1;
      #1;
      chk_zero("rst_async");
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
      @(negedge clk);
      reset = 1'b0;
      bus.valid_in = 1'b0;
      model_reset();
   endtask

   task automatic step(
      input logic       v,
      input logic [7:0] d,
      input logic       m,
      input logic       f0,
      input logic       f1
   );
      logic       tgt;
      logic       rdy;
      logic       acc;
      logic [1:0] st;
      exp_t       e;
      bus.valid_in = v;
      bus.data_in  = d;
      bus.mode     = m;
      bus.full0    = f0;
      bus.full1    = f1;
      #1;
      if (m) begin
         tgt = d[7];
         rdy = tgt ? !f1 : !f0;
      end else begin
         tgt = (m_ptr ? f1 : f0) ? !m_ptr : m_ptr;
         rdy = !(f0 && f1);
      end
      chk("ready_out", {31'd0, bus.ready_out}, {31'd0, rdy});
      acc = v && rdy;
      st = !v ? 2'd0 : (acc ? 2'd1 : 2'd2);
      if (acc) begin
         sb.push_back('{lane: tgt, data: d});
         m_sel = tgt;
         if (tgt) begin
            m_d1 = d;
            m_c1 = m_c1 + 8'd1;
         end else begin
            m_d0 = d;
            m_c0 = m_c0 + 8'd1;
         end
         if (!m)
            m_ptr = !tgt;
      end
      @(posedge clk);
      #1;
      chk("vld_sum",
          {30'd0, {1'b0, bus.validout0} + {1'b0, bus.validout1}},
          {31'd0, acc});
      if (bus.validout0 || bus.validout1) begin
         if (sb.size() == 0) begin
            chk("spurious", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("lane", {31'd0, bus.validout1}, {31'd0, e.lane});
            chk("data",
                {24'd0, e.lane ? bus.dataout1 : bus.dataout0},
                {24'd0, e.data});
         end
      end
      chk("dataout0", {24'd0, bus.dataout0}, {24'd0, m_d0});
      chk("dataout1", {24'd0, bus.dataout1}, {24'd0, m_d1});
      chk("selector", {31'd0, bus.selector}, {31'd0, m_sel});
      chk("estado", {30'd0, bus.estado}, {30'd0, st});
      chk("count0", {24'd0, bus.count0}, {24'd0, cexp(m_c0)});
      chk("count1", {24'd0, bus.count1}, {24'd0, cexp(m_c1)});
      @(negedge clk);
   endtask

   initial begin
      nvec = 0;
      nmis = 0;
      reset = 1'b1;
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
      bus.mode     = 1'b0;
      bus.full0    = 1'b0;
      bus.full1    = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_zero("rst_init");
      reset = 1'b0;

      // round-robin back-to-back
      step(1, 8'h11, 0, 0, 0);
      step(1, 8'h22, 0, 0, 0);
      step(1, 8'h33, 0, 0, 0);
      step(0, 8'h00, 0, 0, 0);

      // ptr = 1 with lane 1 full: goes to lane 0
      step(1, 8'hA5, 0, 0, 1);
      step(0, 8'h00, 0, 0, 0);

      // both full for 3 cycles, then lane 0 frees
      repeat (3) step(1, 8'h5C, 0, 1, 1);
      step(1, 8'h5C, 0, 0, 1);

      // routed mode
      step(1, 8'h80, 1, 0, 0);
      step(1, 8'h7F, 1, 0, 0);
      repeat (2) step(1, 8'h81, 1, 0, 1);
      step(1, 8'h81, 1, 0, 0);
      step(1, 8'h7E, 1, 0, 0);
      step(1, 8'h90, 0, 0, 0);

      // reset mid-stream, then first word lands on lane 0
      step(1, 8'h44, 0, 0, 0);
      do_reset(8'h55);
      step(1, 8'h66, 0, 0, 0);
      step(1, 8'h67, 0, 0, 0);

      // counter wrap on lane 0
      do_reset(8'h00);
      for (int i = 0; i < 256; i++)
         step(1, {1'b0, i[6:0]}, 1, 0, 0);
      chk("count0_wrap", {24'd0, bus.count0}, 0);

      // random traffic
      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) != 0,
              8'($urandom),
              1'($urandom),
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nmis);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running exp finished");
      $fatal(1, "timeout");
   end

endmodule
